// File: rtl/mult_acc_pipe.sv
// Three-stage unsigned multiply-add / multiply-accumulate pipeline.
// S1 registers inputs, S2 registers a*b, S3 registers the result and the running accumulator.
module mult_acc_pipe #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 2 * WIDTH + 4,
  parameter int SAT   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             mode,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  output logic [ACC_W-1:0] data_out,
  output logic             overflow
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = ACC_W + 1;

  if (ACC_W < 2 * WIDTH + 1) begin : g_bad_cfg
    $error("mult_acc_pipe: ACC_W must be at least 2*WIDTH+1");
  end

  // Stage 1
  logic             s1_valid_q, s1_mode_q, s1_clr_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q, s1_c_q;

  // Stage 2
  logic             s2_valid_q, s2_mode_q, s2_clr_q;
  logic [PW-1:0]    s2_prod_q;
  logic [WIDTH-1:0] s2_c_q;

  // Stage 3
  logic             s3_valid_q;
  logic [ACC_W-1:0] data_q, data_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  logic [PW-1:0]    prod;
  logic [ACC_W-1:0] acc_base;
  logic [SW-1:0]    sum;
  logic [ACC_W-1:0] acc_new;

  assign prod = PW'(s1_a_q) * PW'(s1_b_q);

  // acc_q already holds the previous ACC beat's result, so back-to-back beats need no stall.
  assign acc_base = s2_clr_q ? '0 : acc_q;
  assign sum      = {1'b0, acc_base} + SW'(s2_prod_q);

  always_comb begin
    acc_new = sum[ACC_W-1:0];
    if (sum[ACC_W] && (SAT != 0)) begin
      acc_new = '1;
    end
  end

  always_comb begin
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    data_d = data_q;
    if (s2_valid_q) begin
      if (s2_mode_q) begin
        acc_d  = acc_new;
        data_d = acc_new;
        ovf_d  = (s2_clr_q ? 1'b0 : ovf_q) | sum[ACC_W];
      end else begin
        data_d = ACC_W'(s2_prod_q) + ACC_W'(s2_c_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_clr_q   <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_c_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_mode_q  <= 1'b0;
      s2_clr_q   <= 1'b0;
      s2_prod_q  <= '0;
      s2_c_q     <= '0;
      s3_valid_q <= 1'b0;
      data_q     <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
      s1_mode_q  <= mode;
      s1_clr_q   <= acc_clr;
      s1_a_q     <= a;
      s1_b_q     <= b;
      s1_c_q     <= c;
      s2_valid_q <= s1_valid_q;
      s2_mode_q  <= s1_mode_q;
      s2_clr_q   <= s1_clr_q;
      s2_prod_q  <= prod;
      s2_c_q     <= s1_c_q;
      s3_valid_q <= s2_valid_q;
      data_q     <= data_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_valid = s3_valid_q;
  assign data_out  = data_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_mult_acc_pipe.sv
// Bench for mult_acc_pipe: three configurations driven in parallel, checked against a
// transaction-level model plus directed sequences with hand-computed results.
module tb_mult_acc_pipe;

  logic       clk = 1'b0;
  logic       reset, in_valid, mode, acc_clr;
  logic [7:0] a, b, c;

  logic        ov0, ov1, ov2, of0, of1, of2;
  logic [19:0] d0;
  logic [16:0] d1, d2;

  always #5 clk = ~clk;

  mult_acc_pipe #(.WIDTH(8), .ACC_W(20), .SAT(1)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .mode(mode), .acc_clr(acc_clr),
    .a(a), .b(b), .c(c), .out_valid(ov0), .data_out(d0), .overflow(of0)
  );
  mult_acc_pipe #(.WIDTH(8), .ACC_W(17), .SAT(1)) u_sat17 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .mode(mode), .acc_clr(acc_clr),
    .a(a), .b(b), .c(c), .out_valid(ov1), .data_out(d1), .overflow(of1)
  );
  mult_acc_pipe #(.WIDTH(8), .ACC_W(17), .SAT(0)) u_wrap17 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .mode(mode), .acc_clr(acc_clr),
    .a(a), .b(b), .c(c), .out_valid(ov2), .data_out(d2), .overflow(of2)
  );

  logic        dv [3];
  logic [63:0] dd [3];
  logic        dof[3];
  assign dv[0] = ov0;  assign dd[0] = 64'(d0);  assign dof[0] = of0;
  assign dv[1] = ov1;  assign dd[1] = 64'(d1);  assign dof[1] = of1;
  assign dv[2] = ov2;  assign dd[2] = 64'(d2);  assign dof[2] = of2;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: each accepted beat is resolved in arrival order, then its
  // visible result is delayed by three clock edges.
  typedef struct {
    bit     v;
    longint d;
    bit     o;
  } ent_t;

  int unsigned acc_w[3] = '{20, 17, 17};
  bit          sat  [3] = '{1'b1, 1'b1, 1'b0};
  longint      macc [3];
  bit          movf [3];
  ent_t        p0[3], p1[3];
  bit          ev[3];
  longint      ed[3];
  bit          eo[3];

  always @(posedge clk) begin
    ent_t   n;
    ent_t   outv;
    longint prod, sum, maxv;
    for (int m = 0; m < 3; m++) begin
      if (reset) begin
        p0[m] = '{0, 0, 0};
        p1[m] = '{0, 0, 0};
        macc[m] = 0;
        movf[m] = 0;
        ev[m] = 0;
        ed[m] = 0;
        eo[m] = 0;
      end else begin
        n = '{0, 0, 0};
        if (in_valid) begin
          n.v  = 1;
          prod = longint'(a) * longint'(b);
          maxv = (64'sd1 <<< acc_w[m]) - 1;
          if (!mode) begin
            n.d = prod + longint'(c);
          end else begin
            sum = (acc_clr ? 0 : macc[m]) + prod;
            if (acc_clr) movf[m] = 0;
            if (sum > maxv) begin
              movf[m] = 1;
              macc[m] = sat[m] ? maxv : (sum % (maxv + 1));
            end else begin
              macc[m] = sum;
            end
            n.d = macc[m];
          end
          n.o = movf[m];
        end
        outv  = p1[m];
        p1[m] = p0[m];
        p0[m] = n;
        ev[m] = outv.v;
        if (outv.v) begin
          ed[m] = outv.d;
          eo[m] = outv.o;
        end
      end
    end
  end

  longint gotq [3][$];
  bit     gotov[3][$];

  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 3; m++) begin
        check_eq($sformatf("out_valid[%0d]", m), 64'(dv[m]), 64'(ev[m]));
        check_eq($sformatf("data_out[%0d]", m), dd[m], ed[m]);
        check_eq($sformatf("overflow[%0d]", m), 64'(dof[m]), 64'(eo[m]));
        if (dv[m] === 1'b1) begin
          gotq[m].push_back(longint'(dd[m]));
          gotov[m].push_back(dof[m]);
        end
      end
    end
  end

  task automatic drive(input bit r, input bit v, input bit md, input bit cl,
                       input int unsigned aa, input int unsigned bb, input int unsigned cc);
    reset    = r;
    in_valid = v;
    mode     = md;
    acc_clr  = cl;
    a        = aa[7:0];
    b        = bb[7:0];
    c        = cc[7:0];
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic clear_got();
    for (int m = 0; m < 3; m++) begin
      gotq[m].delete();
      gotov[m].delete();
    end
  endtask

  task automatic expect_out(input string tag, input int m, input int idx,
                            input longint exp_d, input bit exp_o);
    if (idx < gotq[m].size()) begin
      check_eq({tag, "_data"}, 64'(gotq[m][idx]), 64'(exp_d));
      check_eq({tag, "_ovf"}, 64'(gotov[m][idx]), 64'(exp_o));
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; mode = 1'b0; acc_clr = 1'b0;
    a = '0; b = '0; c = '0;
    @(negedge clk);
    chk_en = 1'b1;

    // Reset held two cycles with beats presented, then one clean cycle.
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 0, 255, 255, 255);
      check_eq("rst_valid", 64'(ov0), 64'd0);
      check_eq("rst_data", 64'(d0), 64'd0);
      check_eq("rst_ovf", 64'(of0), 64'd0);
    end
    idle(1);
    check_eq("post_rst_valid", 64'(ov0), 64'd0);

    clear_got();
    drive(0, 1, 0, 0, 255, 255, 255);
    idle(5);
    check_eq("muladd_n", 64'(gotq[0].size()), 64'd1);
    expect_out("muladd", 0, 0, 65280, 0);

    clear_got();
    drive(0, 1, 1, 1, 2, 3, 0);
    drive(0, 1, 1, 0, 4, 5, 0);
    drive(0, 1, 1, 0, 10, 10, 0);
    idle(5);
    check_eq("acc_n", 64'(gotq[0].size()), 64'd3);
    expect_out("acc0", 0, 0, 6, 0);
    expect_out("acc1", 0, 1, 26, 0);
    expect_out("acc2", 0, 2, 126, 0);

    clear_got();
    drive(0, 1, 1, 1, 3, 3, 0);
    drive(0, 1, 0, 0, 1, 1, 7);
    drive(0, 1, 1, 0, 1, 1, 0);
    idle(5);
    check_eq("ilv_n", 64'(gotq[0].size()), 64'd3);
    expect_out("ilv0", 0, 0, 9, 0);
    expect_out("ilv1", 0, 1, 8, 0);
    expect_out("ilv2", 0, 2, 10, 0);

    clear_got();
    drive(0, 1, 1, 1, 255, 255, 0);
    drive(0, 1, 1, 0, 255, 255, 0);
    drive(0, 1, 1, 0, 255, 255, 0);
    drive(0, 1, 1, 1, 1, 1, 0);
    idle(5);
    check_eq("sat_n", 64'(gotq[1].size()), 64'd4);
    expect_out("sat0", 1, 0, 65025, 0);
    expect_out("sat1", 1, 1, 130050, 0);
    expect_out("sat2", 1, 2, 131071, 1);
    expect_out("sat3", 1, 3, 1, 0);
    check_eq("wrap_n", 64'(gotq[2].size()), 64'd4);
    expect_out("wrap2", 2, 2, 64003, 1);
    expect_out("wrap3", 2, 3, 1, 0);
    expect_out("wide2", 0, 2, 195075, 0);

    // Mid-stream reset: the two beats still in flight are lost, acc restarts at zero.
    clear_got();
    drive(0, 1, 1, 1, 2, 3, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 0, 2, 3, 0);
    drive(1, 1, 1, 0, 2, 3, 0);
    for (int i = 0; i < 2; i++) drive(0, 1, 1, 0, 2, 3, 0);
    idle(5);
    check_eq("mrst_n", 64'(gotq[0].size()), 64'd4);
    expect_out("mrst0", 0, 0, 6, 0);
    expect_out("mrst1", 0, 1, 12, 0);
    expect_out("mrst2", 0, 2, 6, 0);
    expect_out("mrst3", 0, 3, 12, 0);

    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
            $urandom_range(0, 1), ($urandom_range(0, 7) == 0),
            $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    end
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
